ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
- Parametrised EX→MEM pipeline register for the MIPS core. Successor to the fixed-width writeback-only EX/MEM latch.
- Carries GPR writeback, memory-access descriptor and an optional HI/LO writeback.
- Adds stall hold, bubble insertion, flush, a valid bit, and a multi-cycle accumulate feedback path (hilo_temp/cnt) for two-cycle MADD/MSUB.

Parameters:
- DATA_W, 32, GPR/HI/LO/memory data width.
- ADDR_W, 5, register-file address width.
- OP_W, 8, ALU/memory opcode width.
- CNT_W, 2, multi-cycle step counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stall_ex  in  1  EX stage stalled this cycle.
- stall_mem  in  1  MEM stage stalled this cycle.
- flush  in  1  exception/eret flush; clears stage.
- ex_valid  in  1  EX holds a real instruction.
- ex_reg_write_data  in  DATA_W  GPR result.
- ex_reg_write_addr  in  ADDR_W  GPR destination.
- ex_reg_write_en  in  1  GPR write enable.
- ex_aluop  in  OP_W  opcode forwarded to MEM (load/store decode).
- ex_mem_addr  in  DATA_W  effective address.
- ex_mem_store_data  in  DATA_W  store operand.
- ex_hilo_temp  in  2*DATA_W  partial MADD/MSUB product from EX.
- ex_cnt  in  CNT_W  EX multi-cycle step.
- mem_valid, mem_reg_write_data, mem_reg_write_addr, mem_reg_write_en, mem_aluop, mem_mem_addr, mem_mem_store_data  out  (widths as inputs)  registered copies.
- hilo_temp_o  out  2*DATA_W  partial product fed back to EX.
- cnt_o  out  CNT_W  step counter fed back to EX.
- (feature) ex_hi, ex_lo  in  DATA_W; ex_whilo  in  1; mem_hi, mem_lo  out  DATA_W; mem_whilo  out  1.

Behaviour:
- One clock; reset asynchronous active-high. All outputs, including feature outputs, are 0 in reset.
- Latency: 1 cycle, EX to MEM.
- Each posedge clk applies exactly one action, highest priority first:
  1. flush: clear all registers to 0, including hilo_temp_o and cnt_o.
  2. Bubble (stall_ex=1, stall_mem=0): stage outputs clear to 0 (mem_valid=0, all enables 0). hilo_temp_o<=ex_hilo_temp and cnt_o<=ex_cnt, so a stalled multi-cycle op keeps its partial state.
  3. Hold (stall_mem=1): every register, including hilo_temp_o and cnt_o, keeps its value.
  4. Load (stall_ex=0, stall_mem=0): stage registers take the ex_* inputs. hilo_temp_o<=0 and cnt_o<=0.
- stall_ex=0 with stall_mem=1 is illegal (the stall controller never produces it). It is handled as Hold; no assertion is required.
- When ex_valid=0 on a Load, all write enables are forced to 0 and data fields are still loaded. mem_valid=ex_valid.
- hilo_temp_o and cnt_o change only on Bubble, flush, Load or reset.
- rst asserted mid-operation clears the stage immediately, with no clock needed. Release is synchronous to the next clk edge via the global reset synchroniser.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: EX_MEM_HILO_EN.
- Defined: HI/LO ports and registers exist and follow the same flush/bubble/hold/load rules. mem_whilo is forced to 0 when ex_valid=0.
- Undefined: the HI/LO ports are absent and no HI/LO registers are built. All other behaviour is unchanged.

Decomposition:
- Package pipe_pkg holds:
  - DATA_W/ADDR_W/OP_W defaults.
  - The stall-action encoding (ACT_FLUSH, ACT_BUBBLE, ACT_HOLD, ACT_LOAD).
  - The aluop constants for load/store and MADD/MSUB.
- One sub-module, pipe_ctl: a combinational decode of flush/stall_ex/stall_mem into the one-hot action. It is reused by the IF/ID, ID/EX and MEM/WB registers.

Test Plan:
- Async reset: rst=1 between clock edges → all outputs 0 within the same cycle. First Load after release → outputs follow inputs.
- Load: addr=5'd3, data=32'hDEADBEEF, en=1, ex_valid=1 → next edge mem_* match the inputs and mem_valid=1.
- Hold: stall_ex=1, stall_mem=1 for 3 cycles while inputs change → outputs stay at 32'hDEADBEEF/3.
- Bubble with MADD: stall_ex=1, stall_mem=0, ex_cnt=2'b01, ex_hilo_temp=64'h1_0000_0002 → mem_valid=0, enables 0, cnt_o=1, hilo_temp_o=64'h1_0000_0002. The next Load clears both to 0.
- Flush during Bubble: flush=1, stall_ex=1 → everything 0, including cnt_o.
- ex_valid=0 Load with en=1 (and ex_whilo=1 under EX_MEM_HILO_EN) → mem_reg_write_en=0, mem_whilo=0, data fields loaded.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: default widths,
// the one-hot stall-action encoding and the ALU opcodes seen by MEM.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int OP_W_DEF   = 8;
  localparam int CNT_W_DEF  = 2;

  // One-hot so each register stage can test a single bit per action.
  typedef enum logic [3:0] {
    ACT_FLUSH  = 4'b0001,
    ACT_BUBBLE = 4'b0010,
    ACT_HOLD   = 4'b0100,
    ACT_LOAD   = 4'b1000
  } pipe_act_e;

  localparam logic [7:0] ALUOP_LB   = 8'b1110_0000;
  localparam logic [7:0] ALUOP_LBU  = 8'b1110_0100;
  localparam logic [7:0] ALUOP_LH   = 8'b1110_0001;
  localparam logic [7:0] ALUOP_LHU  = 8'b1110_0101;
  localparam logic [7:0] ALUOP_LW   = 8'b1110_0011;
  localparam logic [7:0] ALUOP_SB   = 8'b1110_1000;
  localparam logic [7:0] ALUOP_SH   = 8'b1110_1001;
  localparam logic [7:0] ALUOP_SW   = 8'b1110_1011;
  localparam logic [7:0] ALUOP_MADD = 8'b1010_0110;
  localparam logic [7:0] ALUOP_MSUB = 8'b1010_1010;

endpackage

// File: rtl/pipe_ctl.sv
// Priority decode of flush/stall into the single action a pipeline
// register applies on the next clock edge.
module pipe_ctl
  import pipe_pkg::*;
(
  input  logic      flush,
  input  logic      stall_ex,
  input  logic      stall_mem,
  output pipe_act_e act
);

  // stall_mem without stall_ex cannot come from the stall controller;
  // it falls through to HOLD so the stage never loses an instruction.
  always_comb begin
    act = ACT_LOAD;
    if (flush)
      act = ACT_FLUSH;
    else if (stall_ex && !stall_mem)
      act = ACT_BUBBLE;
    else if (stall_mem)
      act = ACT_HOLD;
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/bubble/flush and MADD/MSUB feedback.
// Define EX_MEM_HILO_EN to build the HI/LO writeback ports and registers.
module ex_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ex,
  input  logic                stall_mem,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_reg_write_data,
  input  logic [ADDR_W-1:0]   ex_reg_write_addr,
  input  logic                ex_reg_write_en,
  input  logic [OP_W-1:0]     ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_mem_store_data,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [CNT_W-1:0]    ex_cnt,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_reg_write_data,
  output logic [ADDR_W-1:0]   mem_reg_write_addr,
  output logic                mem_reg_write_en,
  output logic [OP_W-1:0]     mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_mem_store_data,
`ifdef EX_MEM_HILO_EN
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
`endif
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o
);

  pipe_act_e act;

  pipe_ctl u_ctl (
    .flush     (flush),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .act       (act)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid          <= 1'b0;
      mem_reg_write_data <= '0;
      mem_reg_write_addr <= '0;
      mem_reg_write_en   <= 1'b0;
      mem_aluop          <= '0;
      mem_mem_addr       <= '0;
      mem_mem_store_data <= '0;
      hilo_temp_o        <= '0;
      cnt_o              <= '0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          mem_valid          <= 1'b0;
          mem_reg_write_data <= '0;
          mem_reg_write_addr <= '0;
          mem_reg_write_en   <= 1'b0;
          mem_aluop          <= '0;
          mem_mem_addr       <= '0;
          mem_mem_store_data <= '0;
          // A bubble keeps the multi-cycle op's partial state alive in EX.
          hilo_temp_o        <= (act == ACT_BUBBLE) ? ex_hilo_temp : '0;
          cnt_o              <= (act == ACT_BUBBLE) ? ex_cnt : '0;
        end
        ACT_LOAD: begin
          mem_valid          <= ex_valid;
          mem_reg_write_data <= ex_reg_write_data;
          mem_reg_write_addr <= ex_reg_write_addr;
          mem_reg_write_en   <= ex_reg_write_en & ex_valid;
          mem_aluop          <= ex_aluop;
          mem_mem_addr       <= ex_mem_addr;
          mem_mem_store_data <= ex_mem_store_data;
          hilo_temp_o        <= '0;
          cnt_o              <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef EX_MEM_HILO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          mem_hi    <= '0;
          mem_lo    <= '0;
          mem_whilo <= 1'b0;
        end
        ACT_LOAD: begin
          mem_hi    <= ex_hi;
          mem_lo    <= ex_lo;
          mem_whilo <= ex_whilo & ex_valid;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: directed plan cases then random
// flush/stall/load traffic checked against a rule-level reference model.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
    logic [7:0]  op;
    logic [31:0] ma;
    logic [31:0] sd;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } obs_t;

`ifdef EX_MEM_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, stall_ex, stall_mem, flush, ex_valid;
  logic [31:0] ex_reg_write_data, ex_mem_addr, ex_mem_store_data;
  logic [4:0]  ex_reg_write_addr;
  logic        ex_reg_write_en;
  logic [7:0]  ex_aluop;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic        mem_valid, mem_reg_write_en;
  logic [31:0] mem_reg_write_data, mem_mem_addr, mem_mem_store_data;
  logic [4:0]  mem_reg_write_addr;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_HILO_EN
  logic [31:0] ex_hi, ex_lo, mem_hi, mem_lo;
  logic        ex_whilo, mem_whilo;
`endif

  ex_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write_data(ex_reg_write_data),
    .ex_reg_write_addr(ex_reg_write_addr), .ex_reg_write_en(ex_reg_write_en),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_mem_store_data(ex_mem_store_data),
    .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_valid(mem_valid), .mem_reg_write_data(mem_reg_write_data),
    .mem_reg_write_addr(mem_reg_write_addr), .mem_reg_write_en(mem_reg_write_en),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_mem_store_data(mem_mem_store_data),
`ifdef EX_MEM_HILO_EN
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
`endif
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  obs_t in_s, model, exp_o, act_o;
  obs_t exp_q[$];
  logic f_s, se_s, sm_s;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  function automatic obs_t actual();
    obs_t a;
    a = '0;
    a.valid = mem_valid;
    a.wd    = mem_reg_write_data;
    a.wa    = mem_reg_write_addr;
    a.we    = mem_reg_write_en;
    a.op    = mem_aluop;
    a.ma    = mem_mem_addr;
    a.sd    = mem_mem_store_data;
    a.hilo  = hilo_temp_o;
    a.cnt   = cnt_o;
`ifdef EX_MEM_HILO_EN
    a.hi    = mem_hi;
    a.lo    = mem_lo;
    a.whilo = mem_whilo;
`endif
    return a;
  endfunction

  task automatic rand_in();
    in_s.valid = ($urandom_range(0, 3) != 0);
    in_s.wd    = $urandom;
    in_s.wa    = 5'($urandom);
    in_s.we    = 1'($urandom);
    in_s.op    = 8'($urandom);
    in_s.ma    = $urandom;
    in_s.sd    = $urandom;
    in_s.hilo  = {$urandom, $urandom};
    in_s.cnt   = 2'($urandom);
    in_s.hi    = $urandom;
    in_s.lo    = $urandom;
    in_s.whilo = 1'($urandom);
  endtask

  // Drive one cycle of stimulus and record what the stage must show after the edge.
  task automatic apply();
    @(negedge clk);
    flush = f_s; stall_ex = se_s; stall_mem = sm_s;
    ex_valid = in_s.valid; ex_reg_write_data = in_s.wd; ex_reg_write_addr = in_s.wa;
    ex_reg_write_en = in_s.we; ex_aluop = in_s.op; ex_mem_addr = in_s.ma;
    ex_mem_store_data = in_s.sd; ex_hilo_temp = in_s.hilo; ex_cnt = in_s.cnt;
`ifdef EX_MEM_HILO_EN
    ex_hi = in_s.hi; ex_lo = in_s.lo; ex_whilo = in_s.whilo;
`endif
    if (f_s) begin
      model = '0;
    end else if (se_s && !sm_s) begin
      model = '0;
      model.hilo = in_s.hilo;
      model.cnt  = in_s.cnt;
    end else if (sm_s) begin
      model = model;
    end else begin
      model = in_s;
      model.we    = in_s.we & in_s.valid;
      model.hi    = HILO ? in_s.hi : 32'd0;
      model.lo    = HILO ? in_s.lo : 32'd0;
      model.whilo = HILO & in_s.whilo & in_s.valid;
      model.hilo  = '0;
      model.cnt   = '0;
    end
    exp_q.push_back(model);
  endtask

  task automatic step(input logic f, input logic se, input logic sm);
    f_s = f; se_s = se; sm_s = sm;
    apply();
  endtask

  // Assert rst between edges and require the outputs to clear without a clock.
  task automatic async_reset(input string tag);
    obs_t r;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 r = actual();
    n_cmp++;
    if (r !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL %s: outputs got %h want 0", tag, r);
    end else begin
      $display("%s ok: outputs cleared mid-cycle", tag);
    end
    model = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_o = exp_q.pop_front();
        act_o = actual();
        n_cmp++;
        n_txn++;
        if (act_o !== exp_o) begin
          n_bad++;
          $display("FAIL txn %0d stage: got %h want %h", n_txn, act_o, exp_o);
        end else begin
          $display("txn %0d ok: valid=%0b addr=%0d data=%h cnt=%0d", n_txn,
                   act_o.valid, act_o.wa, act_o.wd, act_o.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    in_s = '0; model = '0;
    ex_valid = 1'b0; ex_reg_write_data = '0; ex_reg_write_addr = '0; ex_reg_write_en = 1'b0;
    ex_aluop = '0; ex_mem_addr = '0; ex_mem_store_data = '0; ex_hilo_temp = '0; ex_cnt = '0;
`ifdef EX_MEM_HILO_EN
    ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
`endif
    #2;
    act_o = actual();
    n_cmp++;
    if (act_o !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", act_o);
    end
    @(negedge clk);
    rst = 1'b0;

    // Plain load of a GPR write
    rand_in();
    in_s.valid = 1'b1; in_s.wa = 5'd3; in_s.wd = 32'hDEAD_BEEF; in_s.we = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    // Hold for three cycles while the inputs keep changing
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step(1'b0, 1'b1, 1'b1);
    end
    // MADD bubble: partial product survives, stage empties
    rand_in();
    in_s.cnt = 2'b01; in_s.hilo = 64'h1_0000_0002;
    step(1'b0, 1'b1, 1'b0);
    rand_in();
    step(1'b0, 1'b0, 1'b0);
    // Flush during a bubble wipes the feedback state too
    rand_in();
    in_s.cnt = 2'b10;
    step(1'b0, 1'b1, 1'b0);
    rand_in();
    step(1'b1, 1'b1, 1'b0);
    // Invalid instruction: enables drop, data still loads
    rand_in();
    in_s.valid = 1'b0; in_s.we = 1'b1; in_s.whilo = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    // Async reset with a live instruction, then the first load after release
    rand_in();
    in_s.valid = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    async_reset("async_reset");
    rand_in();
    in_s.valid = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int r;
      rand_in();
      r = $urandom_range(0, 99);
      if (r < 8)       step(1'b1, 1'($urandom), 1'($urandom));
      else if (r < 50) step(1'b0, 1'b0, 1'b0);
      else if (r < 72) step(1'b0, 1'b1, 1'b0);
      else if (r < 94) step(1'b0, 1'b1, 1'b1);
      else             step(1'b0, 1'b0, 1'b1);
      if (i == 150) async_reset("async_reset_rand");
    end

    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
